// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU-busy and memory-stall
// hazards plus branch squash. Define HAZARD_PERF_CNT_EN to add 32-bit stall/flush counters.
module hazard_control_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             ID_useRs,
    input  logic             ID_useRt,
    input  logic             ID_mduOp,
    input  logic             ID_readsHiLo,
    input  logic             ID_EX_memRead,
    input  logic [4:0]       ID_EX_writeReg,
    input  logic             branchTaken,
    input  logic             memStall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      loadStallCnt,
    output logic [31:0]      mduStallCnt,
    output logic [31:0]      flushCnt,
`endif
    output logic             mduBusy,
    output logic [CNT_W-1:0] mduRemaining
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               load_use;
    logic               mdu_haz;
    logic               mdu_issue;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ID_EX_memRead && (ID_EX_writeReg != 5'd0) &&
                      ((ID_useRs && (IF_ID_rs == ID_EX_writeReg)) ||
                       (ID_useRt && (IF_ID_rt == ID_EX_writeReg)));
    assign mdu_haz  = (state_reg == MDU_BUSY) && (ID_mduOp || ID_readsHiLo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        mdu_issue    = 1'b0;
        state_next   = state_reg;
        count_next   = count_reg;

        if (memStall) begin
            // Whole pipe frozen; a taken branch stays in EX and re-asserts later.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
        end else if (branchTaken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
        end else if (load_use || mdu_haz) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end else begin
            mdu_issue    = ID_mduOp && (state_reg == RUN);
        end

        // The busy countdown runs independently of any pipeline freeze.
        case (state_reg)
            RUN: begin
                if (mdu_issue) begin
                    count_next = CNT_W'(MDU_LATENCY);
                    state_next = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end
                if (count_reg <= CNT_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                count_next = '0;
            end
        endcase
    end

    assign mduBusy      = (state_reg == MDU_BUSY);
    assign mduRemaining = count_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_cnt_reg, mdu_cnt_reg, flush_cnt_reg;
    logic        load_inc, mdu_inc, flush_inc;

    // Load and MDU stalls are counted independently, so one cycle may bump both.
    assign load_inc  = !memStall && !branchTaken && load_use;
    assign mdu_inc   = !memStall && !branchTaken && mdu_haz;
    assign flush_inc = !memStall && branchTaken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_reg  <= '0;
            mdu_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (load_inc)  load_cnt_reg  <= load_cnt_reg + 32'd1;
            if (mdu_inc)   mdu_cnt_reg   <= mdu_cnt_reg + 32'd1;
            if (flush_inc) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign loadStallCnt = load_cnt_reg;
    assign mduStallCnt  = mdu_cnt_reg;
    assign flushCnt     = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench: stimulus pushes expected output words into a queue,
// a negedge monitor pops and compares against the DUT each cycle.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_writeReg;
    logic       ID_useRs, ID_useRt, ID_mduOp, ID_readsHiLo, ID_EX_memRead;
    logic       branchTaken, memStall;
    logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write;
    logic       mduBusy;
    logic [3:0] mduRemaining;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic [10:0] e;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_control_unit #(.MDU_LATENCY(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_ID_rs       (IF_ID_rs),
        .IF_ID_rt       (IF_ID_rt),
        .ID_useRs       (ID_useRs),
        .ID_useRt       (ID_useRt),
        .ID_mduOp       (ID_mduOp),
        .ID_readsHiLo   (ID_readsHiLo),
        .ID_EX_memRead  (ID_EX_memRead),
        .ID_EX_writeReg (ID_EX_writeReg),
        .branchTaken    (branchTaken),
        .memStall       (memStall),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_write    (ID_EX_write),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_write   (EX_MEM_write),
        .mduBusy        (mduBusy),
        .mduRemaining   (mduRemaining)
    );

    // Enable/flush patterns: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write}
    localparam logic [5:0] P_NORM  = 6'b110101;
    localparam logic [5:0] P_STALL = 6'b000111;
    localparam logic [5:0] P_BR    = 6'b111111;
    localparam logic [5:0] P_MEM   = 6'b000000;

    function automatic logic [10:0] ev(input logic [5:0] pat, input logic busy, input logic [3:0] rem);
        return {pat, busy, rem};
    endfunction

    task automatic drive(input string nm, input logic rst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic mdu, input logic hilo,
                         input logic mrd, input logic [4:0] wr,
                         input logic br, input logic ms,
                         input logic [10:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rst; IF_ID_rs = rs; IF_ID_rt = rt; ID_useRs = urs; ID_useRt = urt;
        ID_mduOp = mdu; ID_readsHiLo = hilo; ID_EX_memRead = mrd; ID_EX_writeReg = wr;
        branchTaken = br; memStall = ms;
        x.nm = nm;
        x.e  = e;
        sb_q.push_back(x);
    endtask

    task automatic idle(input string nm, input logic [10:0] e);
        drive(nm, 1'b1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t x;
            logic [10:0] act;
            x   = sb_q.pop_front();
            act = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write,
                   mduBusy, mduRemaining};
            checks++;
            if (act !== x.e) begin
                failures++;
                $display("FAIL %s: got pat=%b busy=%b rem=%0d, expected pat=%b busy=%b rem=%0d",
                         x.nm, act[10:5], act[4], act[3:0], x.e[10:5], x.e[4], x.e[3:0]);
            end else begin
                $display("ok   %s: pat=%b busy=%b rem=%0d", x.nm, act[10:5], act[4], act[3:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; IF_ID_rs = '0; IF_ID_rt = '0; ID_useRs = 0; ID_useRt = 0;
        ID_mduOp = 0; ID_readsHiLo = 0; ID_EX_memRead = 0; ID_EX_writeReg = '0;
        branchTaken = 0; memStall = 0;

        drive("reset_held", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        idle("after_reset", ev(P_NORM, 0, 0));

        // Load-use on rs, then bubble clears memRead
        drive("load_use_rs", 1'b1, 5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 0, ev(P_STALL, 0, 0));
        drive("load_use_clear", 1'b1, 5'd5, 5'd0, 1, 0, 0, 0, 0, 5'd5, 0, 0, ev(P_NORM, 0, 0));
        drive("load_use_rt", 1'b1, 5'd0, 5'd7, 0, 1, 0, 0, 1, 5'd7, 0, 0, ev(P_STALL, 0, 0));
        drive("reg0_no_stall", 1'b1, 5'd0, 5'd0, 1, 1, 0, 0, 1, 5'd0, 0, 0, ev(P_NORM, 0, 0));
        drive("unused_rt", 1'b1, 5'd3, 5'd9, 1, 0, 0, 0, 1, 5'd9, 0, 0, ev(P_NORM, 0, 0));

        // MDU issue, then mfhi held stalls for 4 cycles
        drive("mdu_issue", 1'b1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        for (int i = 4; i >= 1; i--)
            drive("hilo_stall", 1'b1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ev(P_STALL, 1, 4'(i)));
        drive("hilo_pass", 1'b1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ev(P_NORM, 0, 0));

        // memStall overrides a branch while the counter keeps running
        drive("mdu_issue2", 1'b1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        idle("busy_rem4", ev(P_NORM, 1, 4));
        idle("busy_rem3", ev(P_NORM, 1, 3));
        drive("memstall_rem2", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(P_MEM, 1, 2));
        drive("memstall_rem1", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(P_MEM, 1, 1));
        drive("branch_after_ms", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(P_BR, 0, 0));

        // Branch beats load-use and suppresses MDU issue
        drive("branch_prio", 1'b1, 5'd5, 5'd0, 1, 0, 1, 0, 1, 5'd5, 1, 0, ev(P_BR, 0, 0));
        idle("no_issue_after_br", ev(P_NORM, 0, 0));
        drive("memstall_loaduse", 1'b1, 5'd5, 5'd0, 1, 0, 1, 0, 1, 5'd5, 0, 1, ev(P_MEM, 0, 0));
        idle("no_issue_after_ms", ev(P_NORM, 0, 0));

        // Async reset in the middle of an MDU countdown
        drive("mdu_issue3", 1'b1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        idle("pre_rst_rem4", ev(P_NORM, 1, 4));
        idle("pre_rst_rem3", ev(P_NORM, 1, 3));
        drive("rst_mid_mdu", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        drive("hilo_after_rst", 1'b1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ev(P_NORM, 0, 0));
        idle("final_idle", ev(P_NORM, 0, 0));

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush sequencer for the 5-stage pipeline.
- Detects load-use and multi-cycle multiply/divide (MDU) hazards and freezes on memory stall.
- Squashes wrong-path instructions on taken branch and drives per-stage register write/flush enables.
- Sits beside the forwarding logic; its outputs gate PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
MDU_LATENCY, 4, cycles an issued MDU op occupies the unit before HI/LO is valid (legal 1..15)
CNT_W, 4, width of busy counter; must hold MDU_LATENCY

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
IF_ID_rs  input  5  ID-stage source reg 1
IF_ID_rt  input  5  ID-stage source reg 2
ID_useRs  input  1  ID instruction actually reads rs
ID_useRt  input  1  ID instruction actually reads rt
ID_mduOp  input  1  ID instruction is MDU mult/div
ID_readsHiLo  input  1  ID instruction is mfhi/mflo
ID_EX_memRead  input  1  EX-stage instruction is a load
ID_EX_writeReg  input  5  EX-stage destination reg
branchTaken  input  1  EX resolved taken branch/jump
memStall  input  1  data/instruction memory not ready
PC_write  output  1  PC load enable
IF_ID_write  output  1  IF/ID load enable
IF_ID_flush  output  1  IF/ID clear to NOP
ID_EX_write  output  1  ID/EX load enable
ID_EX_flush  output  1  ID/EX load bubble
EX_MEM_write  output  1  EX/MEM load enable
mduBusy  output  1  MDU occupied
mduRemaining  output  CNT_W  cycles left on MDU

Behaviour:
- Clock/reset fixed: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=RUN, busy counter=0.
  - With all inputs 0: PC_write=1, IF_ID_write=1, ID_EX_write=1, EX_MEM_write=1, IF_ID_flush=0, ID_EX_flush=0, mduBusy=0, mduRemaining=0.
- Enable/flush outputs are combinational from state + inputs, zero-cycle latency. mduBusy/mduRemaining are registered.
- FSM states:
  - RUN: counter==0.
  - MDU_BUSY: counter!=0.
- Hazard terms (register 0 never hazards):
  - loadUse = ID_EX_memRead && ID_EX_writeReg!=0 && ((ID_useRs && IF_ID_rs==ID_EX_writeReg) || (ID_useRt && IF_ID_rt==ID_EX_writeReg)).
  - mduHaz = (state==MDU_BUSY) && (ID_mduOp || ID_readsHiLo).
- Priority per cycle, highest first:
  1. memStall: PC_write=IF_ID_write=ID_EX_write=EX_MEM_write=0; no flushes; branchTaken ignored (branch held in EX, re-asserts); no MDU issue; counter still decrements.
  2. branchTaken: IF_ID_flush=1, ID_EX_flush=1, PC_write=1; ID instruction squashed, so no MDU issue even if ID_mduOp.
  3. loadUse or mduHaz: PC_write=0, IF_ID_write=0, ID_EX_flush=1; no issue.
  4. Otherwise all writes 1, no flush; if ID_mduOp in RUN: issue.
- Issue: counter<=MDU_LATENCY, state->MDU_BUSY at the next edge.
- MDU_BUSY: counter decrements by 1 each edge, regardless of stalls. At counter==1 the next edge gives counter=0, state->RUN.
  - The stalled ID instruction proceeds in the first cycle counter==0.
- Load-use stall lasts exactly 1 cycle: the bubble clears ID_EX_memRead.
- Reset mid-MDU: counter cleared immediately; no pending stall survives.
- Counter never underflows; no issue possible while MDU_BUSY (self-stalls).

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds 32-bit outputs loadStallCnt, mduStallCnt, flushCnt.
  - Each increments by 1 on each clock where priority rule 3 (load/mdu respectively) or rule 2 applies.
  - Wrap modulo 2^32; reset to 0 by rst_n. memStall cycles are not counted.
  - If loadUse and mduHaz are both true in one cycle, both counters increment.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 with counter=3 -> mduRemaining=0, mduBusy=0 immediately; after release all writes=1, flushes=0.
- Load-use: ID_EX_memRead=1, ID_EX_writeReg=5, IF_ID_rs=5, ID_useRs=1 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle (memRead=0) normal.
- Reg 0 / unused operand: writeReg=0 matching rs, or rt match with ID_useRt=0 -> no stall.
- MDU: ID_mduOp=1 in RUN -> mduRemaining 4,3,2,1,0 on next 5 edges. ID_readsHiLo=1 held stalls exactly 4 cycles, then passes with mduRemaining=0.
- Branch priority: branchTaken=1 with loadUse=1 and ID_mduOp=1 -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, no MDU issue (mduBusy stays 0).
- memStall: memStall=1 with branchTaken=1 during MDU_BUSY counter=2 -> all writes 0, no flush, counter 2->1->0 still decrements.
